// File: rtl/bsg_rolly_retry_pkg.sv
// +----------------------------------------------------------------------+
// | Module : bsg_rolly_retry_pkg                                         |
// | Brief  : Shared types for the rolly-FIFO retry transmitter: FSM      |
// |          state encoding and the ACK/NACK response encoding.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package bsg_rolly_retry_pkg;

  typedef enum logic [1:0] {
    ST_SEND   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ROLL   = 2'd3
  } state_e;

  // Value carried on ack_nack_i when ack_v_i is high
  localparam logic c_ack  = 1'b0;
  localparam logic c_nack = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bsg_counter_clear_up.sv
// +----------------------------------------------------------------------+
// | Module : bsg_counter_clear_up                                        |
// | Brief  : Up counter with synchronous clear that saturates at         |
// |          MAX_VAL instead of wrapping.                                |
// | Ports  : clk_i     - clock                                           |
// |          reset_n_i - asynchronous active-low reset                   |
// |          clear_i   - synchronous clear, wins over up_i               |
// |          up_i      - increment request                               |
// |          count_o   - current count                                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module bsg_counter_clear_up #(
  parameter int MAX_VAL = 1,
  parameter int WIDTH   = $clog2(MAX_VAL + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (up_i && (r_count != c_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bsg_rolly_retry_tx.sv
// +----------------------------------------------------------------------+
// | Module : bsg_rolly_retry_tx                                          |
// | Brief  : Packet transmitter sitting on a rolly FIFO. Streams one     |
// |          packet speculatively, waits for an ACK/NACK, then either    |
// |          commits the packet or rewinds and replays it. After         |
// |          max_retry_p replays the packet is dropped and err_v_o        |
// |          pulses.                                                     |
// | Ports  : clk_i, reset_n_i          - clock, async active-low reset   |
// |          fifo_data_i/fifo_v_i      - FIFO head word / valid          |
// |          fifo_yumi_o               - speculative read                |
// |          fifo_deq_v_o              - commit speculative reads        |
// |          fifo_roll_v_o             - rewind to last commit point     |
// |          fifo_clr_v_o              - empty the FIFO                  |
// |          link_data_o/link_v_o      - outgoing word / valid           |
// |          link_ready_i              - link accepts word               |
// |          ack_v_i/ack_nack_i        - link response (1 = NACK)        |
// |          abort_i                   - discard everything, restart     |
// |          err_v_o                   - packet dropped pulse            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module bsg_rolly_retry_tx
  import bsg_rolly_retry_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int pkt_len_p   = 4,
  parameter int timeout_p   = 16,
  parameter int max_retry_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] fifo_data_i,
  input  logic               fifo_v_i,
  output logic               fifo_yumi_o,
  output logic               fifo_deq_v_o,
  output logic               fifo_roll_v_o,
  output logic               fifo_clr_v_o,
  output logic [width_p-1:0] link_data_o,
  output logic               link_v_o,
  input  logic               link_ready_i,
  input  logic               ack_v_i,
  input  logic               ack_nack_i,
  input  logic               abort_i,
  output logic               err_v_o
);

  localparam int c_WORD_W  = $clog2(pkt_len_p + 1);
  localparam int c_TIMER_W = $clog2(timeout_p + 1);
  localparam int c_RETRY_W = $clog2(max_retry_p + 1);

  localparam logic [c_WORD_W-1:0]  c_LAST_WORD = c_WORD_W'(pkt_len_p - 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_END = c_TIMER_W'(timeout_p - 1);
  localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(max_retry_p);

  state_e r_state;
  state_e w_next_state;

  logic [c_WORD_W-1:0]  w_word_cnt;
  logic [c_TIMER_W-1:0] w_timer;
  logic [c_RETRY_W-1:0] w_retry;

  logic w_yumi;
  logic w_last_word;
  logic w_ack_ok;
  logic w_ack_nack;
  logic w_timeout;
  logic w_retry_done;

  // Internal accept strobe; the port copy is additionally gated by reset
  assign w_yumi       = (r_state == ST_SEND) & fifo_v_i & link_ready_i & ~abort_i;
  assign w_last_word  = (w_word_cnt == c_LAST_WORD);
  assign w_ack_ok     = ack_v_i & (ack_nack_i == c_ack);
  assign w_ack_nack   = ack_v_i & (ack_nack_i == c_nack);
  assign w_timeout    = (w_timer == c_TIMER_END);
  assign w_retry_done = (w_retry == c_MAX_RETRY);

  // ---------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------
  bsg_counter_clear_up #(
    .MAX_VAL (pkt_len_p),
    .WIDTH   (c_WORD_W)
  ) u_word_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (abort_i | (w_yumi & w_last_word)),
    .up_i      (w_yumi & ~w_last_word),
    .count_o   (w_word_cnt)
  );

  // Timer only runs in WAIT; leaving WAIT for any reason zeroes it
  bsg_counter_clear_up #(
    .MAX_VAL (timeout_p),
    .WIDTH   (c_TIMER_W)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (abort_i | (r_state != ST_WAIT)),
    .up_i      (r_state == ST_WAIT),
    .count_o   (w_timer)
  );

  bsg_counter_clear_up #(
    .MAX_VAL (max_retry_p),
    .WIDTH   (c_RETRY_W)
  ) u_retry_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (abort_i | (r_state == ST_COMMIT) |
                ((r_state == ST_ROLL) & w_retry_done)),
    .up_i      ((r_state == ST_ROLL) & ~w_retry_done),
    .count_o   (w_retry)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_SEND;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    if (abort_i) begin
      w_next_state = ST_SEND;
    end else begin
      case (r_state)
        ST_SEND: begin
          if (w_yumi && w_last_word) w_next_state = ST_WAIT;
        end
        ST_WAIT: begin
          // A response in the timeout cycle takes priority over the timeout
          if (w_ack_ok)        w_next_state = ST_COMMIT;
          else if (w_ack_nack) w_next_state = ST_ROLL;
          else if (w_timeout)  w_next_state = ST_ROLL;
        end
        ST_COMMIT: w_next_state = ST_SEND;
        ST_ROLL:   w_next_state = ST_SEND;
        default:   w_next_state = ST_SEND;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Everything is forced low while reset is held, so the
  // link sees nothing even though the state already reads SEND.
  // ---------------------------------------------------------------------
  always_comb begin
    fifo_yumi_o   = 1'b0;
    fifo_deq_v_o  = 1'b0;
    fifo_roll_v_o = 1'b0;
    fifo_clr_v_o  = reset_n_i & abort_i;
    link_data_o   = '0;
    link_v_o      = 1'b0;
    err_v_o       = 1'b0;
    if (reset_n_i && !abort_i) begin
      case (r_state)
        ST_SEND: begin
          link_v_o    = fifo_v_i;
          link_data_o = fifo_data_i;
          fifo_yumi_o = fifo_v_i & link_ready_i;
        end
        ST_COMMIT: begin
          fifo_deq_v_o = 1'b1;
        end
        ST_ROLL: begin
          // Out of retries: release the packet rather than replay it
          if (w_retry_done) begin
            fifo_deq_v_o = 1'b1;
            err_v_o      = 1'b1;
          end else begin
            fifo_roll_v_o = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsg_rolly_retry_tx.sv
// +----------------------------------------------------------------------+
// | Module : tb_bsg_rolly_retry_tx                                       |
// | Brief  : Directed self-checking bench for bsg_rolly_retry_tx with a  |
// |          behavioural rolly FIFO upstream.                            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_bsg_rolly_retry_tx;

  localparam int c_W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           fifo_rst_n;
  logic [c_W-1:0] fifo_data;
  logic           fifo_v;
  logic           fifo_yumi;
  logic           fifo_deq_v;
  logic           fifo_roll_v;
  logic           fifo_clr_v;
  logic [c_W-1:0] link_data;
  logic           link_v;
  logic           link_ready;
  logic           ack_v;
  logic           ack_nack;
  logic           abort;
  logic           err_v;

  logic           push_v;
  logic [c_W-1:0] push_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bsg_rolly_retry_tx #(
    .width_p     (c_W),
    .pkt_len_p   (4),
    .timeout_p   (16),
    .max_retry_p (2)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .fifo_data_i   (fifo_data),
    .fifo_v_i      (fifo_v),
    .fifo_yumi_o   (fifo_yumi),
    .fifo_deq_v_o  (fifo_deq_v),
    .fifo_roll_v_o (fifo_roll_v),
    .fifo_clr_v_o  (fifo_clr_v),
    .link_data_o   (link_data),
    .link_v_o      (link_v),
    .link_ready_i  (link_ready),
    .ack_v_i       (ack_v),
    .ack_nack_i    (ack_nack),
    .abort_i       (abort),
    .err_v_o       (err_v)
  );

  // Rolly FIFO model: write pointer, speculative read pointer, commit point
  logic [c_W-1:0] mem [0:255];
  logic [7:0]     wr_p, rd_p, cm_p;

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_p <= '0;
      rd_p <= '0;
      cm_p <= '0;
    end else begin
      if (push_v) begin
        mem[wr_p] <= push_d;
        wr_p      <= wr_p + 8'd1;
      end
      if (fifo_clr_v) begin
        rd_p <= wr_p;
        cm_p <= wr_p;
      end else if (fifo_roll_v) begin
        rd_p <= cm_p;
      end else begin
        if (fifo_yumi)  rd_p <= rd_p + 8'd1;
        if (fifo_deq_v) cm_p <= rd_p;
      end
    end
  end

  assign fifo_v    = (rd_p != wr_p);
  assign fifo_data = mem[rd_p];

  // Event monitor, sampled mid-cycle
  int cyc = 0;
  int beat_n = 0, yumi_n = 0, deq_n = 0, roll_n = 0, err_n = 0;
  int deq_cyc = 0, err_cyc = 0, excl_viol = 0, err_alone = 0;
  logic [c_W-1:0] beats    [0:127];
  int             beat_cyc [0:127];
  int             roll_cyc [0:31];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (link_v && link_ready && beat_n < 128) begin
      beats[beat_n]    <= link_data;
      beat_cyc[beat_n] <= cyc;
      beat_n           <= beat_n + 1;
    end
    if (fifo_yumi) yumi_n <= yumi_n + 1;
    if (fifo_deq_v) begin
      deq_n   <= deq_n + 1;
      deq_cyc <= cyc;
    end
    if (fifo_roll_v && roll_n < 32) begin
      roll_cyc[roll_n] <= cyc;
      roll_n           <= roll_n + 1;
    end
    if (err_v) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
      if (!fifo_deq_v) err_alone <= err_alone + 1;
    end
    if ((int'(fifo_yumi) + int'(fifo_deq_v) + int'(fifo_roll_v)) > 1)
      excl_viol <= excl_viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_v = 1'b1;
      push_d = base + 32'(i);
      tick();
    end
    push_v = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int budget = 200;
    while (beat_n < n && budget > 0) begin
      tick();
      budget--;
    end
    check("wait_beats", beat_n, n);
  endtask

  task automatic wait_rolls(input int n);
    int budget = 200;
    while (roll_n < n && budget > 0) begin
      tick();
      budget--;
    end
    check("wait_rolls", roll_n, n);
  endtask

  task automatic send_ack(input logic nack);
    ack_v    = 1'b1;
    ack_nack = nack;
    tick();
    ack_v    = 1'b0;
    ack_nack = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    fifo_rst_n = 1'b0;
    link_ready = 1'b1;
    ack_v      = 1'b0;
    ack_nack   = 1'b0;
    abort      = 1'b0;
    push_v     = 1'b0;
    push_d     = '0;
    tick(); tick(); tick();
    reset_n    = 1'b1;
    fifo_rst_n = 1'b1;
    #1;
    check("reset_link_v", link_v, 0);
    check("reset_yumi", fifo_yumi, 0);
    check("reset_deq_roll_clr_err", {fifo_deq_v, fifo_roll_v, fifo_clr_v, err_v}, 4'b0000);

    // Clean packet, ACK three cycles into WAIT
    push_words(32'hA0, 4);
    wait_beats(4);
    check("wait_link_v", link_v, 0);
    tick(); tick(); tick();
    send_ack(1'b0);
    check("commit_deq", fifo_deq_v, 1);
    check("commit_no_roll", fifo_roll_v, 0);
    tick();
    for (int i = 0; i < 4; i++) check("pkt1_word", beats[i], 32'hA0 + 32'(i));
    check("pkt1_deq_n", deq_n, 1);
    check("pkt1_roll_n", roll_n, 0);
    check("pkt1_err_n", err_n, 0);

    // NACK once, then ACK the replay
    push_words(32'hA0, 4);
    wait_beats(8);
    tick(); tick();
    send_ack(1'b1);
    check("nack_roll", fifo_roll_v, 1);
    check("nack_no_deq", fifo_deq_v, 0);
    tick();
    wait_beats(12);
    tick();
    send_ack(1'b0);
    check("replay_deq", fifo_deq_v, 1);
    tick();
    for (int i = 0; i < 4; i++) check("replay_word", beats[8+i], 32'hA0 + 32'(i));
    check("pkt2_roll_n", roll_n, 1);
    check("pkt2_deq_n", deq_n, 2);

    // No response: two timeout replays, then the packet is dropped
    push_words(32'hA0, 4);
    push_words(32'hB0, 4);
    wait_rolls(3);
    check("to1_delay", roll_cyc[1] - beat_cyc[15], 17);
    wait_beats(24);
    check("to_replay_w0", beats[16], 32'hA0);
    check("to2_delay", roll_cyc[2] - beat_cyc[19], 17);
    wait_beats(28);
    check("drop_err_n", err_n, 1);
    check("drop_delay", err_cyc - beat_cyc[23], 17);
    check("drop_with_deq", deq_cyc, err_cyc);
    check("next_pkt_w0", beats[24], 32'hB0);
    check("next_pkt_w3", beats[27], 32'hB3);
    // ACK in the very cycle the timer expires wins over the timeout
    repeat (15) tick();
    send_ack(1'b0);
    check("ack_at_timeout_deq", fifo_deq_v, 1);
    check("ack_at_timeout_no_roll", fifo_roll_v, 0);
    tick();
    check("pktB_deq_n", deq_n, 4);

    // Throttled link and a partial packet
    begin
      int y0;
      y0 = yumi_n;
      link_ready = 1'b0;
      push_words(32'hD0, 2);
      check("stall_link_v", link_v, 1);
      check("stall_yumi", fifo_yumi, 0);
      for (int i = 0; i < 8; i++) begin
        link_ready = (i % 2 == 0);
        tick();
      end
      check("partial_beats", beat_n, 30);
      link_ready = 1'b1;
      repeat (5) tick();
      send_ack(1'b0);
      repeat (14) tick();
      check("partial_no_deq", deq_n, 4);
      check("partial_no_roll", roll_n, 3);
      push_words(32'hD2, 2);
      wait_beats(32);
      tick();
      send_ack(1'b0);
      check("partial_deq", fifo_deq_v, 1);
      tick();
      for (int i = 0; i < 4; i++) check("partial_word", beats[28+i], 32'hD0 + 32'(i));
      check("partial_yumis", yumi_n - y0, 4);
      check("partial_deq_n", deq_n, 5);
    end

    // Abort during WAIT
    push_words(32'hE0, 4);
    wait_beats(36);
    tick(); tick();
    abort = 1'b1;
    #1;
    check("abort_clr", fifo_clr_v, 1);
    check("abort_no_yumi_deq_roll", {fifo_yumi, fifo_deq_v, fifo_roll_v}, 3'b000);
    tick();
    abort = 1'b0;
    #1;
    check("abort_clr_once", fifo_clr_v, 0);
    check("abort_fifo_empty", link_v, 0);
    push_words(32'hF0, 4);
    wait_beats(40);
    check("post_abort_w0", beats[36], 32'hF0);
    check("post_abort_w3", beats[39], 32'hF3);
    wait_rolls(4);
    check("post_abort_timeout", roll_cyc[3] - beat_cyc[39], 17);

    // Abort held through reset release
    reset_n    = 1'b0;
    fifo_rst_n = 1'b0;
    abort      = 1'b1;
    #1;
    check("rst_abort_clr_low", fifo_clr_v, 0);
    check("rst_abort_link_v", link_v, 0);
    tick(); tick();
    reset_n    = 1'b1;
    fifo_rst_n = 1'b1;
    #1;
    check("release_abort_clr", fifo_clr_v, 1);
    tick();
    abort = 1'b0;
    #1;
    check("release_clr_done", fifo_clr_v, 0);

    // Reset asserted mid-SEND; upstream FIFO left holding its words
    link_ready = 1'b0;
    push_words(32'hC0, 2);
    check("midsend_link_v", link_v, 1);
    check("midsend_data", link_data, 32'hC0);
    link_ready = 1'b1;
    #1;
    check("midsend_yumi", fifo_yumi, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_link_v", link_v, 0);
    check("async_rst_yumi", fifo_yumi, 0);
    check("async_rst_data", link_data, 0);
    check("async_rst_others", {fifo_deq_v, fifo_roll_v, fifo_clr_v, err_v}, 4'b0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(); tick();

    check("exclusive_strobes", excl_viol, 0);
    check("err_only_with_deq", err_alone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
